// File: rtl/cpu_jtag_pkg.sv
// Shared types and constants for the CPU virtual-JTAG scan master:
// scan FSM states, the 2-bit IR codes and the default DR length.
package cpu_jtag_pkg;

  localparam int CPU_JTAG_DR_W = 38;

  localparam logic [1:0] IR_OCIMEM    = 2'd0;
  localparam logic [1:0] IR_TRACEMEM  = 2'd1;
  localparam logic [1:0] IR_BREAK     = 2'd2;
  localparam logic [1:0] IR_TRACECTRL = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UIR,
    ST_CDR,
    ST_SDR,
    ST_UDR,
    ST_RTI,
    ST_RESP
  } jtag_state_t;

endpackage

// File: rtl/cpu_jtag_tck_gen.sv
// Phase counter for the generated test clock: tck is low for the first
// TCK_HALF clk cycles of each period and high for the second TCK_HALF.
module cpu_jtag_tck_gen #(
  parameter int TCK_HALF = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tck,
  output logic period_end,
  output logic high_end
);

  localparam int P  = 2 * TCK_HALF;
  localparam int CW = (P > 2) ? $clog2(P) : 1;
  localparam logic [CW-1:0] LAST = CW'(P - 1);
  localparam logic [CW-1:0] HALF = CW'(TCK_HALF);

  logic [CW-1:0] cnt_reg;

  // The counter parks at zero whenever no scan is running, so every
  // phase starts on a fresh tck-low half.
  always_ff @(posedge clk) begin
    if (reset || !run) begin
      cnt_reg <= '0;
    end else if (cnt_reg == LAST) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign tck        = run && (cnt_reg >= HALF);
  assign period_end = run && (cnt_reg == LAST);
  // tck is high in the second half, so its high phase ends on the period edge.
  assign high_end   = run && (cnt_reg == LAST);

endmodule

// File: rtl/cpu_jtag_scan_master.sv
// Host-side virtual-JTAG initiator: one command = UIR, CDR, SDR x DR_W, UDR,
// RTI, then the captured tdo word is returned. Option macro:
// CPU_JTAG_SCAN_MASTER_IR_SKIP_EN skips UIR when the IR is unchanged.
module cpu_jtag_scan_master
  import cpu_jtag_pkg::*;
#(
  parameter int TCK_HALF = 2,
  parameter int DR_W     = CPU_JTAG_DR_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_ir,
  input  logic [DR_W-1:0] cmd_dr,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DR_W-1:0] rsp_dr,
  output logic            tck,
  output logic            tdi,
  input  logic            tdo,
  output logic [1:0]      ir_in,
  output logic            vs_uir,
  output logic            vs_cdr,
  output logic            vs_sdr,
  output logic            vs_udr,
  output logic            jtag_state_rti
);

  localparam int BW = $clog2(DR_W + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DR_W - 1);

  jtag_state_t state_reg, state_next;

  logic [DR_W-1:0] sr_reg;
  logic [DR_W-1:0] rsp_dr_reg;
  logic [1:0]      ir_reg;
  logic [BW-1:0]   bit_cnt_reg;

  logic run, period_end, high_end, accept, skip_uir;

  assign run    = (state_reg != ST_IDLE) && (state_reg != ST_RESP);
  assign accept = cmd_valid && (state_reg == ST_IDLE);

`ifdef CPU_JTAG_SCAN_MASTER_IR_SKIP_EN
  logic scan_done_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_done_reg <= 1'b0;
    end else if (state_reg == ST_RTI && period_end) begin
      scan_done_reg <= 1'b1;
    end
  end

  assign skip_uir = scan_done_reg && (cmd_ir == ir_reg);
`else
  assign skip_uir = 1'b0;
`endif

  cpu_jtag_tck_gen #(
    .TCK_HALF (TCK_HALF)
  ) u_tck_gen (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .tck        (tck),
    .period_end (period_end),
    .high_end   (high_end)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (accept)     state_next = skip_uir ? ST_CDR : ST_UIR;
      ST_UIR:  if (period_end) state_next = ST_CDR;
      ST_CDR:  if (period_end) state_next = ST_SDR;
      ST_SDR:  if (period_end && bit_cnt_reg == LAST_BIT) state_next = ST_UDR;
      ST_UDR:  if (period_end) state_next = ST_RTI;
      ST_RTI:  if (period_end) state_next = ST_RESP;
      ST_RESP: if (rsp_ready)  state_next = ST_IDLE;
      default:                 state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready      = (state_reg == ST_IDLE);
    rsp_valid      = (state_reg == ST_RESP);
    vs_uir         = (state_reg == ST_UIR);
    vs_cdr         = (state_reg == ST_CDR);
    vs_sdr         = (state_reg == ST_SDR);
    vs_udr         = (state_reg == ST_UDR);
    jtag_state_rti = (state_reg == ST_RTI);
    tdi            = (state_reg == ST_SDR) ? sr_reg[0] : 1'b0;
  end

  // tdo is sampled into the MSB so the first captured bit ends up in bit 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_reg      <= '0;
      rsp_dr_reg  <= '0;
      ir_reg      <= '0;
      bit_cnt_reg <= '0;
    end else begin
      if (accept) begin
        ir_reg <= cmd_ir;
        sr_reg <= cmd_dr;
      end else if (state_reg == ST_SDR && high_end) begin
        sr_reg <= {tdo, sr_reg[DR_W-1:1]};
      end

      if (state_reg != ST_SDR) begin
        bit_cnt_reg <= '0;
      end else if (high_end) begin
        bit_cnt_reg <= bit_cnt_reg + 1'b1;
      end

      if (state_reg == ST_RTI && period_end) begin
        rsp_dr_reg <= sr_reg;
      end
    end
  end

  assign rsp_dr = rsp_dr_reg;
  assign ir_in  = ir_reg;

endmodule

// File: tb/tb_cpu_jtag_scan_master.sv
// Scoreboard bench: instance 0 runs with TCK_HALF=2, instance 1 with
// TCK_HALF=1; each has a 38-bit target shift register looped on tdi/tdo.
module tb_cpu_jtag_scan_master;

  localparam int DR_W = 38;
  localparam int NI   = 2;
  localparam logic [DR_W-1:0] TGT_INIT = 38'h15_0000_FFFF;

`ifdef CPU_JTAG_SCAN_MASTER_IR_SKIP_EN
  localparam int SKIP_LAT = 165;
  localparam int SKIP_UIR = 0;
`else
  localparam int SKIP_LAT = 169;
  localparam int SKIP_UIR = 4;
`endif

  typedef struct {
    logic [DR_W-1:0] dr;
    int              lat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0]   reset, cmd_valid, rsp_ready, tgt_load;
  logic [1:0]      cmd_ir [NI];
  logic [DR_W-1:0] cmd_dr [NI];
  logic [NI-1:0]   cmd_ready, rsp_valid, tck, tdi;
  logic [NI-1:0]   vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti;
  wire  [NI-1:0]   tdo;
  logic [1:0]      ir_in [NI];
  logic [DR_W-1:0] rsp_dr [NI];

  exp_t exp_q [NI][$];
  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < NI; gi++) begin : g_inst
    logic [DR_W-1:0] tgt;
    logic cap_tdi = 1'b0;
    logic cap_en  = 1'b0;
    logic rv_prev = 1'b0;
    int   acc_cyc = 0;
    exp_t e_cur;

    cpu_jtag_scan_master #(
      .TCK_HALF (2 - gi),
      .DR_W     (DR_W)
    ) u_dut (
      .clk            (clk),
      .reset          (reset[gi]),
      .cmd_valid      (cmd_valid[gi]),
      .cmd_ready      (cmd_ready[gi]),
      .cmd_ir         (cmd_ir[gi]),
      .cmd_dr         (cmd_dr[gi]),
      .rsp_valid      (rsp_valid[gi]),
      .rsp_ready      (rsp_ready[gi]),
      .rsp_dr         (rsp_dr[gi]),
      .tck            (tck[gi]),
      .tdi            (tdi[gi]),
      .tdo            (tdo[gi]),
      .ir_in          (ir_in[gi]),
      .vs_uir         (vs_uir[gi]),
      .vs_cdr         (vs_cdr[gi]),
      .vs_sdr         (vs_sdr[gi]),
      .vs_udr         (vs_udr[gi]),
      .jtag_state_rti (jtag_state_rti[gi])
    );

    // Target: captures tdi on tck rise, shifts (and updates tdo) on tck fall.
    assign tdo[gi] = tgt[0];
    always @(posedge tck[gi]) begin
      cap_tdi <= tdi[gi];
      cap_en  <= vs_sdr[gi];
    end
    always @(negedge tck[gi] or posedge tgt_load[gi]) begin
      if (tgt_load[gi]) tgt <= TGT_INIT;
      else if (cap_en)  tgt <= {cap_tdi, tgt[DR_W-1:1]};
    end

    always @(posedge clk) begin
      if (cmd_valid[gi] && cmd_ready[gi]) acc_cyc <= cyc;
    end

    // Monitor: pop and compare on each rising rsp_valid.
    always @(negedge clk) begin
      if (rsp_valid[gi] && !rv_prev) begin
        if (exp_q[gi].size() == 0) begin
          check($sformatf("rsp%0d_unexpected", gi), 64'(rsp_valid[gi]), 64'd0);
        end else begin
          e_cur = exp_q[gi].pop_front();
          $display("rsp[%0d] dr=%h lat=%0d (exp dr=%h lat=%0d)", gi, rsp_dr[gi],
                   cyc - acc_cyc, e_cur.dr, e_cur.lat);
          check($sformatf("rsp%0d_dr", gi), 64'(rsp_dr[gi]), 64'(e_cur.dr));
          check($sformatf("rsp%0d_lat", gi), 64'(cyc - acc_cyc), 64'(e_cur.lat));
        end
      end
      rv_prev = rsp_valid[gi];
    end
  end

  int ob_multi, ob_uir, ob_sdr, ob_udr, ob_ir_bad, ob_tck_stuck;
  logic ob_first_tdi;

  task automatic push_exp(input int idx, input logic [DR_W-1:0] dr, input int lat);
    exp_t e;
    e.dr  = dr;
    e.lat = lat;
    exp_q[idx].push_back(e);
  endtask

  task automatic issue(input int idx, input logic [1:0] ir, input logic [DR_W-1:0] dr);
    int guard = 0;
    while (!cmd_ready[idx] && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready[idx]) check("cmd_ready_timeout", 64'(cmd_ready[idx]), 64'd1);
    cmd_ir[idx]    = ir;
    cmd_dr[idx]    = dr;
    cmd_valid[idx] = 1'b1;
    @(negedge clk);
    cmd_valid[idx] = 1'b0;
  endtask

  // Samples scan cycles starting at cycle 1 until rsp_valid or max_cyc.
  task automatic observe(input int idx, input logic [1:0] ir_exp, input int max_cyc, input bit expect_rsp);
    int   n = 0;
    logic prev_tck = 1'b1;
    bit   sdr_seen = 1'b0;
    ob_multi = 0; ob_uir = 0; ob_sdr = 0; ob_udr = 0; ob_ir_bad = 0; ob_tck_stuck = 0;
    ob_first_tdi = 1'bx;
    while (!rsp_valid[idx] && n < max_cyc) begin
      if ($countones({vs_uir[idx], vs_cdr[idx], vs_sdr[idx], vs_udr[idx], jtag_state_rti[idx]}) != 1)
        ob_multi++;
      if (vs_uir[idx]) ob_uir++;
      if (vs_sdr[idx]) ob_sdr++;
      if (vs_udr[idx]) ob_udr++;
      if (vs_sdr[idx] && !sdr_seen) begin
        ob_first_tdi = tdi[idx];
        sdr_seen     = 1'b1;
      end
      if (ir_in[idx] !== ir_exp) ob_ir_bad++;
      if (tck[idx] === prev_tck) ob_tck_stuck++;
      prev_tck = tck[idx];
      n++;
      @(negedge clk);
    end
    if (expect_rsp && !rsp_valid[idx]) check("rsp_timeout", 64'(rsp_valid[idx]), 64'd1);
  endtask

  task automatic check_reset_outputs(input int idx, input string tag);
    check({tag, "_ctrl"}, 64'({cmd_ready[idx], rsp_valid[idx], tck[idx], tdi[idx], vs_uir[idx],
                               vs_cdr[idx], vs_sdr[idx], vs_udr[idx], jtag_state_rti[idx]}),
          64'(9'b1_0000_0000));
    check({tag, "_ir_in"}, 64'(ir_in[idx]), 64'd0);
    check({tag, "_rsp_dr"}, 64'(rsp_dr[idx]), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int hold_nv, hold_dr, hold_rdy;
    reset = '1; tgt_load = '1; cmd_valid = '0; rsp_ready = '0;
    for (int i = 0; i < NI; i++) begin
      cmd_ir[i] = '0;
      cmd_dr[i] = '0;
    end
    repeat (4) @(negedge clk);
    reset = '0; tgt_load = '0;
    @(negedge clk);
    check_reset_outputs(0, "reset0");
    check_reset_outputs(1, "reset1");

    // Scan A: BREAK, target preloaded.
    push_exp(0, TGT_INIT, 169);
    issue(0, 2'd2, 38'h2A_5555_5555);
    observe(0, 2'd2, 400, 1'b1);
    check("a_onehot_viol", 64'(ob_multi), 64'd0);
    check("a_uir_cycles", 64'(ob_uir), 64'd4);
    check("a_sdr_cycles", 64'(ob_sdr), 64'd152);
    check("a_udr_cycles", 64'(ob_udr), 64'd4);
    check("a_ir_in_bad", 64'(ob_ir_bad), 64'd0);
    check("a_first_tdi", 64'(ob_first_tdi), 64'd1);
    check("a_target_dr", 64'(g_inst[0].tgt), 64'(38'h2A_5555_5555));

    // Hold response with rsp_ready low; busy-time commands must be dropped.
    hold_nv = 0; hold_dr = 0; hold_rdy = 0;
    for (int i = 0; i < 20; i++) begin
      cmd_ir[0]    = 2'd1;
      cmd_dr[0]    = '1;
      cmd_valid[0] = i[0];
      if (!rsp_valid[0]) hold_nv++;
      if (rsp_dr[0] !== TGT_INIT) hold_dr++;
      if (cmd_ready[0]) hold_rdy++;
      @(negedge clk);
    end
    cmd_valid[0] = 1'b0;
    check("hold_rsp_valid_drop", 64'(hold_nv), 64'd0);
    check("hold_rsp_dr_change", 64'(hold_dr), 64'd0);
    check("hold_cmd_ready_high", 64'(hold_rdy), 64'd0);
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    rsp_ready[0] = 1'b0;
    check("ack_rsp_valid", 64'(rsp_valid[0]), 64'd0);
    check("ack_cmd_ready", 64'(cmd_ready[0]), 64'd1);
    check("ack_ir_in_kept", 64'(ir_in[0]), 64'd2);

    // Scan B: reset lands on the edge ending cycle 80 (mid-SDR).
    issue(0, 2'd1, 38'h3F_0F0F_0F0F);
    observe(0, 2'd1, 79, 1'b0);
    check("b_sdr_before_reset", 64'(vs_sdr[0]), 64'd1);
    reset[0] = 1'b1;
    @(negedge clk);
    check_reset_outputs(0, "midreset");
    reset[0] = 1'b0; tgt_load[0] = 1'b1;
    @(negedge clk);
    tgt_load[0] = 1'b0;
    repeat (20) begin
      if (vs_udr[0]) ob_udr++;
      @(negedge clk);
    end
    check("b_udr_seen", 64'(ob_udr), 64'd0);
    check("b_no_rsp", 64'(exp_q[0].size()), 64'd0);

    // Scans C and D back to back with the same IR.
    rsp_ready[0] = 1'b1;
    push_exp(0, TGT_INIT, 169);
    issue(0, 2'd0, 38'h00_1234_5678);
    observe(0, 2'd0, 400, 1'b1);
    check("c_first_tdi", 64'(ob_first_tdi), 64'd0);
    check("c_uir_cycles", 64'(ob_uir), 64'd4);
    push_exp(0, 38'h00_1234_5678, SKIP_LAT);
    issue(0, 2'd0, 38'h0A_BCDE_F012);
    observe(0, 2'd0, 400, 1'b1);
    check("d_uir_cycles", 64'(ob_uir), 64'(SKIP_UIR));
    check("d_onehot_viol", 64'(ob_multi), 64'd0);
    @(negedge clk);
    rsp_ready[0] = 1'b0;

    // TCK_HALF=1 instance: tck toggles every clk during the scan.
    rsp_ready[1] = 1'b1;
    push_exp(1, TGT_INIT, 85);
    issue(1, 2'd3, 38'h2A_5555_5555);
    observe(1, 2'd3, 200, 1'b1);
    check("h1_tck_stuck", 64'(ob_tck_stuck), 64'd0);
    check("h1_sdr_cycles", 64'(ob_sdr), 64'd76);
    check("h1_onehot_viol", 64'(ob_multi), 64'd0);
    check("h1_target_dr", 64'(g_inst[1].tgt), 64'(38'h2A_5555_5555));

    repeat (5) @(negedge clk);
    check("q0_drained", 64'(exp_q[0].size()), 64'd0);
    check("q1_drained", 64'(exp_q[1].size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_jtag_scan_master.md
# cpu_jtag_scan_master

Host-side initiator for the CPU's 2-bit-IR virtual-JTAG debug channel. It drives the tck/tdi/virtual-state signals the debug module's tck-domain logic consumes. It accepts a command (IR code plus 38-bit DR word) from an on-chip controller and performs one full scan: UIR, CDR, SDR×38, UDR, RTI. It then returns the 38 tdo bits captured during SDR. It replaces the sld_virtual_jtag_basic hub in self-hosted debug and simulation builds.

## Interface
Parameters:
- TCK_HALF, 2: clk cycles per tck half-period (≥1); P = 2·TCK_HALF clk cycles per tck period.
- DR_W, 38: DR scan length in bits.

Ports:
- clk  in  1  single clock; everything is synchronous to it.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE with no response pending.
- cmd_ir  in  2  IR code: 0 OCIMEM, 1 TRACEMEM, 2 BREAK, 3 TRACECTRL.
- cmd_dr  in  DR_W  word shifted out, LSB first.
- rsp_valid  out  1  captured word available.
- rsp_ready  in  1  response consumed.
- rsp_dr  out  DR_W  captured tdo word; bit 0 is the first bit sampled.
- tck  out  1  generated test clock.
- tdi  out  1  serial data to target.
- tdo  in  1  serial data from target.
- ir_in  out  2  IR value presented to target.
- vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti  out  1 each  virtual-state strobes.

## Operation
- States: IDLE → UIR → CDR → SDR → UDR → RTI → RESP → IDLE.
- Accept: cmd_valid & cmd_ready on a clk edge latches cmd_ir into ir_in and cmd_dr into the shift register, then enters UIR.
- Phase length: UIR, CDR, UDR and RTI each last exactly one tck period (P clk). Exactly one matching strobe is high for that whole period. SDR lasts DR_W periods with vs_sdr high throughout.
- tck waveform: low for the first TCK_HALF cycles of each period, high for the second. tck is low in IDLE and RESP.
- Shifting: during SDR, tdi = sr[0]. At the clk edge ending each tck-high half, sample tdo into sr[DR_W-1] and shift sr right by one.
- Completion: after DR_W shifts, sr holds the captured word. On RTI exit it is copied to rsp_dr and rsp_valid rises.
- Response: rsp_valid and rsp_dr hold until rsp_ready. Return to IDLE on the cycle rsp_valid & rsp_ready. A new command is accepted on the following cycle at the earliest.
- Other states: ir_in holds its last value. tdi = 0 outside SDR.
- cmd_valid outside IDLE is ignored and not queued.

## Timing
- Reset values: cmd_ready=1, rsp_valid=0, rsp_dr=0, tck=0, tdi=0, ir_in=0, all strobes 0, state IDLE, phase counter 0.
- Reset mid-scan: aborts on the next edge with the outputs above. No response is produced and the target sees no UDR.
- Latency: accept at edge 0, so UIR strobe is high from cycle 1. rsp_valid first high at cycle (4+DR_W)·P+1, which is 169 with the defaults.
- Strobe boundaries: phase transitions are gapless. No two strobes are ever high in the same cycle.
- First SDR bit: tdi = cmd_dr[0] from the first SDR cycle. The first tdo sample lands at the end of SDR cycle P.

## Configuration
- CPU_JTAG_SCAN_MASTER_IR_SKIP_EN:
  - Defined: if cmd_ir equals the current ir_in and at least one scan has completed since reset, UIR is skipped and the FSM goes IDLE→CDR. Latency drops by P (165 with defaults).
  - Undefined: UIR is always performed.

## Structure
- Package cpu_jtag_pkg holds:
  - state enum;
  - IR code constants (IR_OCIMEM, IR_TRACEMEM, IR_BREAK, IR_TRACECTRL);
  - DR_W default of 38.
- Sub-module cpu_jtag_tck_gen: phase counter producing tck plus single-cycle period_end and high_end strobes. The FSM advances only on these strobes.

## Test plan
- Reset, then cmd_ir=2, cmd_dr=38'h2A_5555_5555 with tdo looped from tdi via a 38-bit target shift model → rsp_dr equals the target's preloaded 38'h15_0000_FFFF; rsp_valid at cycle 169.
- Strobe check → exactly one of uir/cdr/sdr/udr/rti high per cycle from cycle 1; vs_sdr high for 152 cycles; ir_in=2 throughout.
- rsp_ready held low for 20 cycles → rsp_valid and rsp_dr stable; cmd_ready=0; cmd_valid pulses ignored.
- Reset asserted at cycle 80 (mid-SDR) → next cycle all outputs at reset values; no vs_udr ever seen; a following command completes normally.
- With IR_SKIP_EN: two back-to-back cmd_ir=0 scans → second has no vs_uir and rsp_valid 165 cycles after accept. Without the macro → 169 cycles.
- TCK_HALF=1 → tck toggles every clk; capture still bit-exact.
